// File: rtl/traffic_request_ctrl.sv
// traffic_request_ctrl
// Request conditioner that sits in front of the traffic light controller.
// Each raw input goes through a 2-flop synchroniser and a debounce counter,
// then a registered rising-edge detect. A detected press latches a pending
// request, which stays up until the controller acknowledges it. A single
// prioritised next-phase code is presented, with starvation protection.
//
// Optional feature: define PED_REQ_EN to build the pedestrian channel.
// Without it, ped_btn and ack_ped are ignored, req_ped is 0, and
// next_dir never takes 11.
//
// Parameters:
//   DEBOUNCE_CYCLES  stable samples needed to accept a new level (>= 2)
//   WAIT_LIMIT       pending cycles before a request counts as urgent
// Ports:
//   clk                       system clock, rising edge
//   reset                     asynchronous reset, active low
//   sensor_ns/ew, ped_btn     raw asynchronous inputs
//   ack_ns/ew/ped             one-cycle service acknowledges from the controller
//   req_ns/ew/ped             pending request flags (registered)
//   urgent                    some pending request has waited >= WAIT_LIMIT
//   next_dir                  00 none, 01 NS, 10 EW, 11 PED (registered)
module traffic_request_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int WAIT_LIMIT      = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sensor_ns,
  input  logic       sensor_ew,
  input  logic       ped_btn,
  input  logic       ack_ns,
  input  logic       ack_ew,
  input  logic       ack_ped,
  output logic       req_ns,
  output logic       req_ew,
  output logic       req_ped,
  output logic       urgent,
  output logic [1:0] next_dir
);

  // Debounce count never exceeds DEBOUNCE_CYCLES-1.
  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

  // Channel index: 0 = NS, 1 = EW, 2 = PED (only when built).
`ifdef PED_REQ_EN
  localparam int NCH = 3;
`else
  localparam int NCH = 2;
`endif

  logic [NCH-1:0] raw_v;
  logic [NCH-1:0] ack_v;
  logic [NCH-1:0] pend_v;
  logic [NCH-1:0] urg_v;
  logic           ped_pend;
  logic           ped_urg;

`ifdef PED_REQ_EN
  assign raw_v    = {ped_btn, sensor_ew, sensor_ns};
  assign ack_v    = {ack_ped, ack_ew, ack_ns};
  assign ped_pend = pend_v[2];
  assign ped_urg  = urg_v[2];
`else
  logic unused_ped;
  assign unused_ped = ped_btn ^ ack_ped;
  assign raw_v      = {sensor_ew, sensor_ns};
  assign ack_v      = {ack_ew, ack_ns};
  assign ped_pend   = 1'b0;
  assign ped_urg    = 1'b0;
`endif

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic          sync1, sync2;
    logic [CW-1:0] cnt;
    logic          deb, deb_d, rise;
    logic          pend;
    logic [15:0]   wcnt;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        sync1 <= 1'b0;
        sync2 <= 1'b0;
        cnt   <= '0;
        deb   <= 1'b0;
        deb_d <= 1'b0;
        rise  <= 1'b0;
        pend  <= 1'b0;
        wcnt  <= '0;
      end else begin
        sync1 <= raw_v[i];
        sync2 <= sync1;

        if (sync2 == deb) begin
          cnt <= '0;
        end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          deb <= sync2;
          cnt <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end

        // Registered edge pulse: req rises DEBOUNCE_CYCLES+3 edges after
        // the first sample of a clean input edge.
        deb_d <= deb;
        rise  <= deb & ~deb_d;

        // A fresh press beats a simultaneous ack.
        if (rise)          pend <= 1'b1;
        else if (ack_v[i]) pend <= 1'b0;

        // An ack on a pending request restarts the wait, even if a new
        // press keeps the request alive.
        if (ack_v[i] && pend)           wcnt <= '0;
        else if (pend && wcnt != '1)    wcnt <= wcnt + 16'd1;
      end
    end

    assign pend_v[i] = pend;
    assign urg_v[i]  = pend && (wcnt >= 16'(WAIT_LIMIT));
  end

  // last_served: 1 = EW served last (so NS wins the next tie), 0 = NS.
  logic       last_served;
  logic [1:0] dir_n;

  always_comb begin
    dir_n = 2'b00;
    if (ped_urg)                    dir_n = 2'b11;
    else if (urg_v[0])              dir_n = 2'b01;
    else if (urg_v[1])              dir_n = 2'b10;
    else if (ped_pend)              dir_n = 2'b11;
    else if (pend_v[0] && pend_v[1]) dir_n = last_served ? 2'b01 : 2'b10;
    else if (pend_v[0])             dir_n = 2'b01;
    else if (pend_v[1])             dir_n = 2'b10;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_served <= 1'b1;
      next_dir    <= 2'b00;
      urgent      <= 1'b0;
    end else begin
      if (ack_ew)      last_served <= 1'b1;
      else if (ack_ns) last_served <= 1'b0;
      next_dir <= dir_n;
      urgent   <= |urg_v;
    end
  end

  assign req_ns  = pend_v[0];
  assign req_ew  = pend_v[1];
  assign req_ped = ped_pend;

endmodule
